// File: rtl/reduce_arbiter_pkg.sv
// Shared types and opcodes for the round-robin reduce arbiter.
// Purely declarative: no latency, no backpressure.
package reduce_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    EVAL = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/reduce_arbiter_if.sv
// Requester-side bundle of the reduce arbiter: level req/data/op in, one-hot ack pulse out.
// No latency of its own; requesters hold req until their ack pulse.
interface reduce_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3,
  parameter int IDXW  = 2
);
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] data_i;
  logic [2*NREQ-1:0]     op_i;
  logic [NREQ-1:0]       ack_o;
  logic                  res_o;
  logic                  err_o;
  logic                  busy_o;
  logic [IDXW-1:0]       gnt_idx_o;

  modport master (
    output req_i, data_i, op_i,
    input  ack_o, res_o, err_o, busy_o, gnt_idx_o
  );

  modport slave (
    input  req_i, data_i, op_i,
    output ack_o, res_o, err_o, busy_o, gnt_idx_o
  );
endinterface

// File: rtl/reduce_arbiter_unit.sv
// Shared combinational OR/AND/XOR reduction of one WIDTH-bit operand; zero latency.
// Reserved opcode yields 0; no handshake, evaluated whenever inputs change.
module reduce_unit
  import reduce_arb_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic             q
);

  always_comb begin
    q = 1'b0;
    case (op)
      OP_OR:   q = |d;
      OP_AND:  q = &d;
      OP_XOR:  q = ^d;
      default: q = 1'b0;
    endcase
  end

endmodule

// File: rtl/reduce_arbiter.sv
// Round-robin arbiter sharing one reduce_unit among NREQ level requesters.
// Grant at edge N, one-hot ack in the cycle after edge N+3; requests wait (level held) while busy.
module reduce_arbiter
  import reduce_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3,
  parameter int IDXW  = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rstn,
  reduce_arbiter_if.slave bus
);

  state_e            state_q;
  logic [IDXW-1:0]   rr_q;
  logic [IDXW-1:0]   gnt_q;
  logic [WIDTH-1:0]  dat_q;
  logic [1:0]        op_q;
  logic              res_q;
  logic [NREQ-1:0]   ack_q;
  logic              res_out_q;
  logic              err_q;

  logic              gnt_vld_d;
  logic [IDXW-1:0]   gnt_d;
  logic [WIDTH-1:0]  dat_d;
  logic [1:0]        op_d;
  logic [IDXW-1:0]   rr_d;
  logic              unit_q;

  // Walk from the farthest offset down to rr so the nearest pending requester wins.
  always_comb begin
    logic [NREQ-1:0]       req_sh;
    logic [NREQ*WIDTH-1:0] dat_sh;
    logic [2*NREQ-1:0]     op_sh;
    int                    k;
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    dat_d     = '0;
    op_d      = OP_OR;
    req_sh    = '0;
    dat_sh    = '0;
    op_sh     = '0;
    k         = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k      = (int'(rr_q) + i) % NREQ;
      req_sh = bus.req_i >> k;
      dat_sh = bus.data_i >> (k * WIDTH);
      op_sh  = bus.op_i >> (2 * k);
      if (req_sh[0]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = IDXW'(k);
        dat_d     = dat_sh[WIDTH-1:0];
        op_d      = op_sh[1:0];
      end
    end
  end

  assign rr_d = (gnt_q == IDXW'(NREQ - 1)) ? '0 : gnt_q + IDXW'(1);

  reduce_unit #(.WIDTH(WIDTH)) u_unit (
    .d  (dat_q),
    .op (op_q),
    .q  (unit_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      dat_q     <= '0;
      op_q      <= OP_OR;
      res_q     <= 1'b0;
      ack_q     <= '0;
      res_out_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q     <= '0;
      res_out_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            gnt_q   <= gnt_d;
            dat_q   <= dat_d;
            op_q    <= op_d;
            state_q <= CAPT;
          end
        end
        CAPT: state_q <= EVAL;
        EVAL: begin
          res_q   <= unit_q;
          state_q <= ACK;
        end
        ACK: begin
          // Outputs are registered here, so the pulse lands in the first IDLE cycle.
          ack_q     <= NREQ'(1) << gnt_q;
          res_out_q <= res_q;
          err_q     <= (op_q == OP_RSV);
          rr_q      <= rr_d;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.res_o     = res_out_q;
  assign bus.err_o     = err_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.gnt_idx_o = gnt_q;

endmodule

// File: tb/tb_reduce_arbiter.sv
// Randomized + directed scoreboard bench for reduce_arbiter against a grant-level reference model.
module tb_reduce_arbiter;
  import reduce_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 3;
  localparam int IDXW  = 2;

  typedef struct {
    int   k;
    logic res;
    logic err;
    int   at_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reduce_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  reduce_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Requester view: 0 idle, 1 waiting for grant, 2 granted awaiting ack.
  int               st[NREQ];
  int               ack_at[NREQ];
  int               ack_cnt[NREQ];
  logic [WIDTH-1:0] dat_m[NREQ];
  logic [1:0]       op_m[NREQ];
  logic [NREQ-1:0]  req_m = '0;
  exp_t             sb[$];
  int  rr_m = 0, free_edge = 0, last_k = 0, prev_k = 0, last_g = -100;
  int  hold_grants = 0;
  bit  in_reset = 1'b1, hold_mode = 1'b0, early_en = 1'b0, scramble_en = 1'b0;
  int  vecs = 0, errs = 0;

  function automatic logic ref_reduce(logic [WIDTH-1:0] d, logic [1:0] op);
    case (op)
      OP_OR:   return d != 0;
      OP_AND:  return d == {WIDTH{1'b1}};
      OP_XOR:  return ($countones(d) % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
    vecs++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      bus.data_i[k*WIDTH +: WIDTH] = dat_m[k];
      bus.op_i[2*k +: 2]           = op_m[k];
    end
    bus.req_i = req_m;
  endtask

  task automatic raise(int k, logic [WIDTH-1:0] d, logic [1:0] o);
    st[k]    = 1;
    req_m[k] = 1'b1;
    dat_m[k] = d;
    op_m[k]  = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    for (int k = 0; k < NREQ; k++) begin
      if (st[k] == 2 && ack_at[k] == cyc) begin
        if (hold_mode) begin
          st[k]    = 1;
          dat_m[k] = WIDTH'($urandom);
          op_m[k]  = 2'($urandom);
        end else begin
          st[k]    = 0;
          req_m[k] = 1'b0;
        end
      end else if (st[k] == 2) begin
        if (scramble_en) begin
          dat_m[k] = WIDTH'($urandom);
          op_m[k]  = 2'($urandom);
        end
        if (early_en && $urandom_range(0, 7) == 0) req_m[k] = 1'b0;
      end
    end
  endtask

  // Decide what the arbiter grants at the coming edge and queue the expected ack.
  task automatic commit();
    int   k;
    exp_t e;
    drive();
    k = -1;
    if (!in_reset && cyc + 1 >= free_edge && req_m != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (rr_m + i) % NREQ;
        if (k < 0 && req_m[j]) k = j;
      end
      e.k = k;
      e.res = ref_reduce(dat_m[k], op_m[k]);
      e.err = (op_m[k] == OP_RSV);
      e.at_edge = cyc + 4;
      sb.push_back(e);
      st[k] = 2;
      ack_at[k] = cyc + 4;
      prev_k = last_k;
      last_k = k;
      last_g = cyc + 1;
      free_edge = cyc + 5;
      rr_m = (k + 1) % NREQ;
      if (hold_mode) begin
        hold_grants++;
        if (hold_grants == 16) begin
          hold_mode = 1'b0;
          for (int j = 0; j < NREQ; j++)
            if (st[j] == 1) begin
              st[j] = 0;
              req_m[j] = 1'b0;
            end
          drive();
        end
      end
    end
  endtask

  task automatic wait_idle(int bound);
    int  n;
    bit  pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < bound) begin
      tick();
      commit();
      n++;
      pend = (sb.size() != 0);
      for (int k = 0; k < NREQ; k++) if (st[k] == 2) pend = 1'b1;
    end
    if (pend) begin
      vecs++;
      errs++;
      $display("FAIL drain timeout: %0d expectations outstanding after %0d cycles, required 0", sb.size(), bound);
    end
  endtask

  task automatic do_reset(int ncyc, logic [NREQ-1:0] mask);
    in_reset = 1'b1;
    rstn = 1'b0;
    req_m = mask;
    for (int k = 0; k < NREQ; k++) st[k] = 0;
    drive();
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(bus.ack_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_gnt", 32'(bus.gnt_idx_o), 0);
    check("rst_res", 32'(bus.res_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    sb.delete();
    rr_m = 0;
    last_k = 0;
    prev_k = 0;
    last_g = -100;
    req_m = '0;
    drive();
    rstn = 1'b1;
    free_edge = cyc + 1;
    in_reset = 1'b0;
  endtask

  task automatic single(int k, logic [WIDTH-1:0] d, logic [1:0] o);
    tick();
    raise(k, d, o);
    commit();
    wait_idle(20);
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      logic [NREQ-1:0] exp_ack;
      exp_t e;
      exp_ack = '0;
      if (sb.size() > 0 && sb[0].at_edge == cyc) exp_ack[sb[0].k] = 1'b1;
      check("ack", 32'(bus.ack_o), 32'(exp_ack));
      check("busy", 32'(bus.busy_o), 32'(cyc >= last_g && cyc < last_g + 3));
      check("gnt_idx", 32'(bus.gnt_idx_o), (cyc >= last_g) ? last_k : prev_k);
      for (int k = 0; k < NREQ; k++) if (bus.ack_o[k]) ack_cnt[k]++;
      if (exp_ack != '0) begin
        e = sb.pop_front();
        check("res", 32'(bus.res_o), 32'(e.res));
        check("err", 32'(bus.err_o), 32'(e.err));
      end
    end
  end

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      st[k] = 0; ack_at[k] = 0; ack_cnt[k] = 0; dat_m[k] = '0; op_m[k] = OP_OR;
    end
    drive();

    do_reset(2, 4'b1111);

    single(0, 3'b010, OP_OR);
    single(0, 3'b010, OP_AND);
    single(0, 3'b111, OP_XOR);
    single(2, WIDTH'($urandom), OP_RSV);

    // Operand changes during CAPT must not reach the result.
    tick();
    raise(1, 3'b000, OP_OR);
    commit();
    tick();
    dat_m[1] = 3'b111;
    commit();
    wait_idle(20);

    do_reset(1, '0);
    for (int k = 0; k < NREQ; k++) ack_cnt[k] = 0;
    hold_mode = 1'b1;
    hold_grants = 0;
    tick();
    for (int k = 0; k < NREQ; k++) raise(k, WIDTH'($urandom), 2'($urandom));
    commit();
    wait_idle(200);
    for (int k = 0; k < NREQ; k++) check("fair_cnt", 32'(ack_cnt[k]), 4);

    // Reset during EVAL aborts the transaction.
    tick();
    raise(1, 3'b101, OP_OR);
    commit();
    tick();
    commit();
    tick();
    do_reset(1, '0);
    tick();
    commit();
    single(3, 3'b001, OP_XOR);

    scramble_en = 1'b1;
    early_en = 1'b1;
    repeat (400) begin
      tick();
      for (int k = 0; k < NREQ; k++)
        if (st[k] == 0 && $urandom_range(0, 3) == 0)
          raise(k, WIDTH'($urandom), 2'($urandom));
      commit();
    end
    scramble_en = 1'b0;
    early_en = 1'b0;
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
